// File: rtl/mux8way16_sync.sv
// 8-way, WIDTH-bit multiplexer built as a three-level 2:1 tree, with the result captured in an enabled output register.
// Define MUX8WAY16_COMB_OUT_EN to add out_comb, the unregistered tree output.
module mux8way16_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       sel,
`ifdef MUX8WAY16_COMB_OUT_EN
    output logic [WIDTH-1:0] out_comb,
`endif
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_ab, w_cd, w_ef, w_gh;
    logic [WIDTH-1:0] w_abcd, w_efgh;
    logic [WIDTH-1:0] w_mux;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;

    // Level 1 uses sel[0], level 2 uses sel[1], and level 3 uses sel[2].
    assign w_ab   = sel[0] ? b : a;
    assign w_cd   = sel[0] ? d : c;
    assign w_ef   = sel[0] ? f : e;
    assign w_gh   = sel[0] ? h : g;
    assign w_abcd = sel[1] ? w_cd : w_ab;
    assign w_efgh = sel[1] ? w_gh : w_ef;
    assign w_mux  = sel[2] ? w_efgh : w_abcd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (en) begin
            r_out       <= w_mux;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

`ifdef MUX8WAY16_COMB_OUT_EN
    assign out_comb = w_mux;
`endif

endmodule

// File: tb/tb_mux8way16_sync.sv
// Directed bench for mux8way16_sync. It covers reset, the full select sweep, hold, reset priority and lane independence.
// The comb-path test is built only when MUX8WAY16_COMB_OUT_EN is defined.
module tb_mux8way16_sync;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [2:0]  sel;
    logic [15:0] out;
    logic        out_valid;
`ifdef MUX8WAY16_COMB_OUT_EN
    logic [15:0] out_comb;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    mux8way16_sync #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .en(en),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .sel(sel),
`ifdef MUX8WAY16_COMB_OUT_EN
        .out_comb(out_comb),
`endif
        .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, and outputs are sampled at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic common_data();
        a = 16'h000F; b = 16'h00F0; c = 16'h00FF; d = 16'h0F00;
        e = 16'h0F0F; f = 16'h0FF0; g = 16'h0FFF; h = 16'hF000;
    endtask

    task automatic test_reset();
        common_data();
        reset = 1'b1; en = 1'b1; sel = 3'b111;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (out !== 16'h0000) $display("FAIL reset_out[%0d] got %h want 0000", i, out);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL reset_valid[%0d] got %b want 0", i, out_valid);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        logic [15:0] exp_tbl [8];
        exp_tbl[0] = 16'h000F; exp_tbl[1] = 16'h00F0; exp_tbl[2] = 16'h00FF; exp_tbl[3] = 16'h0F00;
        exp_tbl[4] = 16'h0F0F; exp_tbl[5] = 16'h0FF0; exp_tbl[6] = 16'h0FFF; exp_tbl[7] = 16'hF000;
        common_data();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            step();
            n_checks++;
            if (out !== exp_tbl[i]) $display("FAIL sweep_out[sel=%0d] got %h want %h", i, out, exp_tbl[i]);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1) $display("FAIL sweep_valid[sel=%0d] got %b want 1", i, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        common_data();
        en = 1'b1; sel = 3'b101;
        step();
        n_checks++;
        if (out !== 16'h0FF0) $display("FAIL hold_capture got %h want 0ff0", out);
        else n_pass++;
        en = 1'b0; sel = 3'b000; a = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out !== 16'h0FF0) $display("FAIL hold_out[%0d] got %h want 0ff0", i, out);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL hold_valid[%0d] got %b want 0", i, out_valid);
            else n_pass++;
        end
        common_data();
    endtask

    task automatic test_reset_priority();
        common_data();
        en = 1'b1; sel = 3'b111; reset = 1'b1;
        step();
        n_checks++;
        if (out !== 16'h0000) $display("FAIL rstprio_out got %h want 0000", out);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rstprio_valid got %b want 0", out_valid);
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (out !== 16'hF000) $display("FAIL rstprio_after_out got %h want f000", out);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rstprio_after_valid got %b want 1", out_valid);
        else n_pass++;
    endtask

    task automatic test_lanes();
        a = 16'hA5A5; b = '0; c = '0; d = '0; e = '0; f = '0; g = '0; h = '0;
        en = 1'b1; sel = 3'b000;
        step();
        n_checks++;
        if (out !== 16'hA5A5) $display("FAIL lanes_a got %h want a5a5", out);
        else n_pass++;
        sel = 3'b001;
        step();
        n_checks++;
        if (out !== 16'h0000) $display("FAIL lanes_b got %h want 0000", out);
        else n_pass++;
    endtask

`ifdef MUX8WAY16_COMB_OUT_EN
    task automatic test_comb();
        common_data();
        en = 1'b0; reset = 1'b1; sel = 3'b011;
        #1;
        n_checks++;
        if (out_comb !== 16'h0F00) $display("FAIL comb_same_cycle got %h want 0f00", out_comb);
        else n_pass++;
        step();
        n_checks++;
        if (out_comb !== 16'h0F00) $display("FAIL comb_in_reset got %h want 0f00", out_comb);
        else n_pass++;
        n_checks++;
        if (out !== 16'h0000) $display("FAIL comb_reg_out got %h want 0000", out);
        else n_pass++;
        sel = 3'b111;
        #1;
        n_checks++;
        if (out_comb !== 16'hF000) $display("FAIL comb_sel7 got %h want f000", out_comb);
        else n_pass++;
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; en = 1'b0; sel = 3'b000;
        common_data();
        test_reset();
        test_sweep();
        test_hold();
        test_reset_priority();
        test_lanes();
`ifdef MUX8WAY16_COMB_OUT_EN
        test_comb();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
